// File: rtl/homography_arbiter.sv
// Two-requester front end for the shared homography query engine: one pending
// slot per requester, round-robin grant, single outstanding transaction, timeout.

module homography_arbiter_slot #(
  parameter int CW = 20
) (
  input  logic          clk_25,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          clr_i,
  input  logic [CW-1:0] c_i,
  output logic          pend_o,
  output logic          ovf_o,
  output logic [CW-1:0] c_o
);
  logic          pend_q;
  logic [CW-1:0] c_q;

  // A start that lands on the completion cycle refills the slot instead of dropping.
  assign ovf_o  = start_i & pend_q & ~clr_i;
  assign pend_o = pend_q;
  assign c_o    = c_q;

  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      c_q    <= '0;
    end else if (start_i && (!pend_q || clr_i)) begin
      pend_q <= 1'b1;
      c_q    <= c_i;
    end else if (clr_i) begin
      pend_q <= 1'b0;
    end
  end
endmodule

module homography_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 10
) (
  input  logic        clk_25,
  input  logic        rst_n,
  input  logic        req0_start,
  input  logic [9:0]  req0_x,
  input  logic [9:0]  req0_y,
  input  logic        req1_start,
  input  logic [9:0]  req1_x,
  input  logic [9:0]  req1_y,
  output logic        ready0,
  output logic        ready1,
  output logic [9:0]  ret_x,
  output logic [9:0]  ret_y,
  output logic [4:0]  ret_r,
  output logic [5:0]  ret_g,
  output logic [4:0]  ret_b,
  output logic [9:0]  hom_query_x,
  output logic [9:0]  hom_query_y,
  output logic        hom_start,
  input  logic [9:0]  hom_return_x,
  input  logic [9:0]  hom_return_y,
  input  logic [4:0]  hom_r,
  input  logic [5:0]  hom_g,
  input  logic [4:0]  hom_b,
  input  logic        hom_ready,
  output logic        busy,
  output logic        timeout_err,
  output logic        overflow_err
);
  localparam int NREQ = 2;
  localparam int CW   = 10;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } coord_t;

  typedef struct packed {
    coord_t     c;
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } resp_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic   [NREQ-1:0] start, pend, clr, ovf;
  coord_t [NREQ-1:0] req_c, pend_c;

  assign start    = {req1_start, req0_start};
  assign req_c[0] = {req0_x, req0_y};
  assign req_c[1] = {req1_x, req1_y};

  for (genvar g = 0; g < NREQ; g++) begin : g_slot
    homography_arbiter_slot #(.CW(2*CW)) u_slot (
      .clk_25 (clk_25),
      .rst_n  (rst_n),
      .start_i(start[g]),
      .clr_i  (clr[g]),
      .c_i    (req_c[g]),
      .pend_o (pend[g]),
      .ovf_o  (ovf[g]),
      .c_o    (pend_c[g])
    );
  end

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            rr_q, rr_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            hstart_q, hstart_d;
  coord_t          query_q, query_d;
  logic [NREQ-1:0] ready_q, ready_d;
  resp_t           ret_q, ret_d;
  logic            busy_q, busy_d;
  logic            tmo_q, tmo_d;
  logic            ovf_q, ovf_d;
  logic            gid;

  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      rr_q     <= 1'b0;
      cnt_q    <= '0;
      hstart_q <= 1'b0;
      query_q  <= '0;
      ready_q  <= '0;
      ret_q    <= '0;
      busy_q   <= 1'b0;
      tmo_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      hstart_q <= hstart_d;
      query_q  <= query_d;
      ready_q  <= ready_d;
      ret_q    <= ret_d;
      busy_q   <= busy_d;
      tmo_q    <= tmo_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    hstart_d = 1'b0;
    query_d  = query_q;
    ready_d  = '0;
    ret_d    = ret_q;
    busy_d   = busy_q;
    tmo_d    = tmo_q;
    ovf_d    = ovf_q | (|ovf);
    clr      = '0;
    gid      = (&pend) ? rr_q : pend[1];
    unique case (state_q)
      S_IDLE: begin
        if (|pend) begin
          hstart_d = 1'b1;
          query_d  = pend_c[gid];
          owner_d  = gid;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // An engine answer on the timeout cycle is still a real answer.
        if (hom_ready || cnt_q == TO_W'(TIMEOUT)) begin
          ready_d[owner_q] = 1'b1;
          clr[owner_q]     = 1'b1;
          rr_d             = ~owner_q;
          busy_d           = 1'b0;
          state_d          = S_IDLE;
          if (hom_ready) begin
            ret_d = {hom_return_x, hom_return_y, hom_r, hom_g, hom_b};
          end else begin
            ret_d = '0;
            tmo_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ready0       = ready_q[0];
  assign ready1       = ready_q[1];
  assign ret_x        = ret_q.c.x;
  assign ret_y        = ret_q.c.y;
  assign ret_r        = ret_q.r;
  assign ret_g        = ret_q.g;
  assign ret_b        = ret_q.b;
  assign hom_query_x  = query_q.x;
  assign hom_query_y  = query_q.y;
  assign hom_start    = hstart_q;
  assign busy         = busy_q;
  assign timeout_err  = tmo_q;
  assign overflow_err = ovf_q;
endmodule

// File: tb/tb_homography_arbiter.sv
// Bench for homography_arbiter: engine model, per-requester scoreboards,
// a vector table for arbitration order plus hand sequences for corner cases.

module tb_homography_arbiter;
  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_start, req1_start;
  logic [9:0] req0_x, req0_y, req1_x, req1_y;
  logic       ready0, ready1;
  logic [9:0] ret_x, ret_y;
  logic [4:0] ret_r, ret_b;
  logic [5:0] ret_g;
  logic [9:0] hom_query_x, hom_query_y;
  logic       hom_start;
  logic [9:0] hom_return_x, hom_return_y;
  logic [4:0] hom_r, hom_b;
  logic [5:0] hom_g;
  logic       hom_ready;
  logic       busy, timeout_err, overflow_err;

  homography_arbiter #(.TIMEOUT(TMO), .TO_W(10)) dut (
    .clk_25(clk), .rst_n(rst_n),
    .req0_start(req0_start), .req0_x(req0_x), .req0_y(req0_y),
    .req1_start(req1_start), .req1_x(req1_x), .req1_y(req1_y),
    .ready0(ready0), .ready1(ready1),
    .ret_x(ret_x), .ret_y(ret_y), .ret_r(ret_r), .ret_g(ret_g), .ret_b(ret_b),
    .hom_query_x(hom_query_x), .hom_query_y(hom_query_y), .hom_start(hom_start),
    .hom_return_x(hom_return_x), .hom_return_y(hom_return_y),
    .hom_r(hom_r), .hom_g(hom_g), .hom_b(hom_b), .hom_ready(hom_ready),
    .busy(busy), .timeout_err(timeout_err), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // engine model
  int         eng_lat  = 1;
  logic       eng_mute = 1'b0;
  logic [4:0] eng_r    = 5'h1F;
  logic [5:0] eng_g    = 6'h20;
  logic [4:0] eng_b    = 5'h0A;
  int         stray_req = 0;
  int         stray_done = 0;
  int         eng_cd = 0;
  logic       eng_act = 1'b0;
  logic [9:0] eq_x, eq_y;
  logic [19:0] q_log[$];
  int          start_cyc[$];

  function automatic logic [35:0] exp_ret(input logic [9:0] x, input logic [9:0] y);
    logic [9:0] rx, ry;
    rx = x + 10'd1;
    ry = y - 10'd1;
    return {rx, ry, eng_r, eng_g, eng_b};
  endfunction

  always @(negedge clk) begin
    hom_ready = 1'b0;
    if (stray_req != stray_done) begin
      stray_done++;
      hom_ready    = 1'b1;
      hom_return_x = 10'h3FF;
      hom_return_y = 10'h155;
    end
    if (hom_start) begin
      eq_x = hom_query_x;
      eq_y = hom_query_y;
      q_log.push_back({hom_query_x, hom_query_y});
      start_cyc.push_back(cyc);
      eng_cd  = eng_lat;
      eng_act = 1'b1;
    end else if (eng_act && eng_cd > 0) begin
      eng_cd--;
    end
    if (eng_act && eng_cd == 0) begin
      eng_act = 1'b0;
      if (!eng_mute) begin
        hom_ready = 1'b1;
        {hom_return_x, hom_return_y, hom_r, hom_g, hom_b} = exp_ret(eq_x, eq_y);
      end
    end
  end

  // response monitor / scoreboard
  logic [35:0] exp0[$], exp1[$];
  int          served_ids[$];
  int          ready_cyc[$];
  int          n_served = 0;

  always @(negedge clk) begin
    logic [35:0] e;
    if (ready0 && ready1) chk("ready_exclusive", {ready1, ready0}, 2'b01);
    if (ready0 || ready1) begin
      served_ids.push_back(ready1 ? 1 : 0);
      ready_cyc.push_back(cyc);
      n_served++;
      if (ready1 ? exp1.size() == 0 : exp0.size() == 0) begin
        chk("unexp_ready", {ready1, ready0}, 2'b00);
      end else begin
        e = ready1 ? exp1.pop_front() : exp0.pop_front();
        chk($sformatf("ret%0d", ready1 ? 1 : 0), {ret_x, ret_y, ret_r, ret_g, ret_b}, e);
      end
    end
  end

  task automatic issue(input logic v0, input logic [9:0] x0, input logic [9:0] y0,
                       input logic v1, input logic [9:0] x1, input logic [9:0] y1,
                       output int t);
    @(negedge clk);
    req0_start = v0; req0_x = x0; req0_y = y0;
    req1_start = v1; req1_x = x1; req1_y = y1;
    t = cyc;
    @(negedge clk);
    req0_start = 1'b0;
    req1_start = 1'b0;
  endtask

  task automatic wait_served(input int target, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (n_served >= target) return;
    end
    chk("wait_served", n_served, target);
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {ready0, ready1, ret_x, ret_y, ret_r, ret_g, ret_b, hom_query_x,
             hom_query_y, hom_start, busy, timeout_err, overflow_err}, 64'd0);
  endtask

  typedef struct {
    logic       v0;
    logic [9:0] x0, y0;
    logic       v1;
    logic [9:0] x1, y1;
    int         lat;
    int         first;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int t, base, qb, sb, rb, n, w;
    vecs[0] = '{1'b1, 10'd100, 10'd200, 1'b0, 10'd0,   10'd0,    3, 0};
    vecs[1] = '{1'b1, 10'd10,  10'd10,  1'b1, 10'd20,  10'd20,   1, 1};
    vecs[2] = '{1'b0, 10'd0,   10'd0,   1'b1, 10'd300, 10'd400,  2, 1};
    vecs[3] = '{1'b1, 10'd7,   10'd8,   1'b1, 10'd9,   10'd11,   0, 0};
    vecs[4] = '{1'b1, 10'd1023,10'd0,   1'b0, 10'd0,   10'd0,    3, 0};
    vecs[5] = '{1'b0, 10'd0,   10'd0,   1'b1, 10'd0,   10'd1023, 2, 1};

    rst_n = 1'b0;
    req0_start = 0; req1_start = 0;
    req0_x = 0; req0_y = 0; req1_x = 0; req1_y = 0;
    hom_return_x = 0; hom_return_y = 0; hom_r = 0; hom_g = 0; hom_b = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_outputs");
    rst_n = 1'b1;

    // table: arbitration order, grant latency, turnaround
    for (int i = 0; i < 6; i++) begin
      eng_lat = vecs[i].lat;
      base = n_served; qb = q_log.size(); sb = start_cyc.size(); rb = ready_cyc.size();
      issue(vecs[i].v0, vecs[i].x0, vecs[i].y0, vecs[i].v1, vecs[i].x1, vecs[i].y1, t);
      if (vecs[i].v0) exp0.push_back(exp_ret(vecs[i].x0, vecs[i].y0));
      if (vecs[i].v1) exp1.push_back(exp_ret(vecs[i].x1, vecs[i].y1));
      n = int'(vecs[i].v0) + int'(vecs[i].v1);
      wait_served(base + n, 40);
      if (served_ids.size() > base) chk($sformatf("v%0d_first", i), served_ids[base], vecs[i].first);
      if (start_cyc.size() > sb) chk($sformatf("v%0d_start_lat", i), start_cyc[sb] - t, 2);
      if (q_log.size() > qb)
        chk($sformatf("v%0d_query", i), q_log[qb], vecs[i].first == 1 ?
            {vecs[i].x1, vecs[i].y1} : {vecs[i].x0, vecs[i].y0});
      if (n == 2 && start_cyc.size() > sb + 1 && ready_cyc.size() > rb)
        chk($sformatf("v%0d_turnaround", i), start_cyc[sb+1] - ready_cyc[rb], 1);
    end
    chk("errs_clean", {timeout_err, overflow_err}, 2'b00);

    // overflow: second req1 while pend1 held and engine busy with req0
    eng_lat = 3; eng_r = 5'h03; eng_g = 6'h11; eng_b = 5'h1C;
    base = n_served; qb = q_log.size();
    issue(1'b1, 10'd30, 10'd30, 1'b0, 10'd0, 10'd0, t);
    exp0.push_back(exp_ret(10'd30, 10'd30));
    @(negedge clk);
    req1_start = 1'b1; req1_x = 10'd5; req1_y = 10'd5;
    @(negedge clk);
    req1_start = 1'b0;
    exp1.push_back(exp_ret(10'd5, 10'd5));
    chk("ovf_not_yet", overflow_err, 1'b0);
    issue(1'b0, 10'd0, 10'd0, 1'b1, 10'd6, 10'd6, t);
    chk("ovf_set", overflow_err, 1'b1);
    wait_served(base + 2, 40);
    if (q_log.size() > qb + 1) chk("ovf_kept_coord", q_log[qb+1], {10'd5, 10'd5});
    repeat (6) @(negedge clk);
    chk("ovf_no_extra", n_served, base + 2);

    // hom_ready exactly on the timeout cycle wins
    eng_lat = TMO;
    base = n_served; sb = start_cyc.size(); rb = ready_cyc.size();
    issue(1'b0, 10'd0, 10'd0, 1'b1, 10'd70, 10'd80, t);
    exp1.push_back(exp_ret(10'd70, 10'd80));
    wait_served(base + 1, 40);
    if (start_cyc.size() > sb && ready_cyc.size() > rb)
      chk("edge_ready_cyc", ready_cyc[rb] - start_cyc[sb], TMO + 1);
    chk("edge_no_tmo", timeout_err, 1'b0);

    // stray hom_ready while idle
    base = n_served;
    stray_req++;
    repeat (4) @(negedge clk);
    chk("stray_ignored", n_served, base);

    // timeout: engine silent
    eng_mute = 1'b1;
    base = n_served; sb = start_cyc.size(); rb = ready_cyc.size();
    issue(1'b1, 10'd50, 10'd60, 1'b0, 10'd0, 10'd0, t);
    exp0.push_back(36'd0);
    @(negedge clk);
    chk("tmo_busy", busy, 1'b1);
    wait_served(base + 1, 40);
    if (start_cyc.size() > sb && ready_cyc.size() > rb)
      chk("tmo_ready_cyc", ready_cyc[rb] - start_cyc[sb], TMO + 1);
    chk("tmo_flags", {timeout_err, busy}, 2'b10);
    eng_mute = 1'b0; eng_lat = 2;
    base = n_served;
    issue(1'b1, 10'd51, 10'd61, 1'b0, 10'd0, 10'd0, t);
    exp0.push_back(exp_ret(10'd51, 10'd61));
    wait_served(base + 1, 40);
    chk("tmo_sticky", timeout_err, 1'b1);

    // reset during S_WAIT: late answer ignored, rr back to requester 0
    eng_lat = 3;
    sb = start_cyc.size();
    issue(1'b1, 10'd90, 10'd91, 1'b0, 10'd0, 10'd0, t);
    w = 0;
    while (start_cyc.size() == sb && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk("rst_saw_start", start_cyc.size(), sb + 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_all_zero("rst_mid_outputs");
    base = n_served;
    repeat (6) @(negedge clk);
    chk("rst_late_ready_ignored", n_served, base);
    eng_lat = 1;
    qb = q_log.size();
    issue(1'b1, 10'd40, 10'd41, 1'b1, 10'd42, 10'd43, t);
    exp0.push_back(exp_ret(10'd40, 10'd41));
    exp1.push_back(exp_ret(10'd42, 10'd43));
    wait_served(base + 2, 40);
    if (served_ids.size() > base) chk("rst_rr_first", served_ids[base], 0);
    if (q_log.size() > qb) chk("rst_first_query", q_log[qb], {10'd40, 10'd41});
    chk("rst_errs_cleared", {timeout_err, overflow_err}, 2'b00);
    chk("sb_drained", exp0.size() + exp1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time limit hit");
    $fatal(1, "global timeout");
  end
endmodule
